// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CONV = 2'b01,
      DONE = 2'b10
   } state_e;

   localparam logic [3:0] ERR_DIGIT = 4'hF;

   // ceil(bits * log10(2)) in fixed point; smallest digit count that holds 2^bits-1
   function automatic int min_digits(input int bits);
      return (bits * 30103 + 99999) / 100000;
   endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between the divider side and the BCD converter.
// Carries the blank vector only when BIN2BCD_BLANK_EN is defined.
interface bin2bcd_seq_if #(
   parameter int BITSIZE = 16,
   parameter int DIGITS  = 5
);
   logic                  strt;
   logic [BITSIZE-1:0]    bin_in;
   logic                  in_invalid;
   logic [4*DIGITS-1:0]   bcd;
   logic                  done;
   logic                  idle;
`ifdef BIN2BCD_BLANK_EN
   logic [DIGITS-1:0]     blank;

   modport master (output strt, bin_in, in_invalid, input bcd, done, idle, blank);
   modport slave  (input strt, bin_in, in_invalid, output bcd, done, idle, blank);
`else
   modport master (output strt, bin_in, in_invalid, input bcd, done, idle);
   modport slave  (input strt, bin_in, in_invalid, output bcd, done, idle);
`endif
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj (
   input  logic [3:0] din,
   output logic [3:0] dout
);
   assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock.
// Optional BIN2BCD_BLANK_EN adds a registered leading-zero blank vector.
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int BITSIZE   = 16,
   parameter int INDEXSIZE = 4,
   parameter int DIGITS    = 5
) (
   input logic           clk,
   input logic           rst,
   bin2bcd_seq_if.slave  bus
);
   localparam int W = 4 * DIGITS;

   generate
      if (DIGITS < min_digits(BITSIZE)) begin : g_digits_chk
         $error("bin2bcd_seq: DIGITS too small for BITSIZE");
      end
   endgenerate

   state_e                state_q, state_d;
   logic [BITSIZE-1:0]    bin_q, bin_d;
   logic [W-1:0]          work_q, work_d;
   logic [INDEXSIZE-1:0]  cnt_q, cnt_d;
   logic [W-1:0]          bcd_q, bcd_d;
   logic [W-1:0]          adj;
   logic                  unused_adj_msb;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (work_q[4*g +: 4]),
         .dout (adj[4*g +: 4])
      );
   end

   // The top adjusted bit is shifted out; the DIGITS bound keeps it zero.
   assign unused_adj_msb = adj[W-1];

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      case (state_q)
         IDLE: begin
            if (bus.strt) begin
               if (bus.in_invalid) begin
                  work_d  = {DIGITS{ERR_DIGIT}};
                  state_d = DONE;
               end else begin
                  bin_d   = bus.bin_in;
                  work_d  = '0;
                  cnt_d   = INDEXSIZE'(BITSIZE - 1);
                  state_d = CONV;
               end
            end
         end
         CONV: begin
            work_d = {adj[W-2:0], bin_q[BITSIZE-1]};
            bin_d  = {bin_q[BITSIZE-2:0], 1'b0};
            cnt_d  = cnt_q - INDEXSIZE'(1);
            if (cnt_q == '0) state_d = DONE;
         end
         DONE: begin
            bcd_d   = work_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bin_q   <= '0;
         work_q  <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
      end
   end

   assign bus.bcd  = bcd_q;
   assign bus.done = (state_q == DONE);
   assign bus.idle = (state_q == IDLE);

`ifdef BIN2BCD_BLANK_EN
   logic [DIGITS-1:0] blank_q, blank_d;
   logic              zero_above;

   // Error digits are nonzero, so the invalid path naturally yields blank=0.
   always_comb begin
      blank_d    = blank_q;
      zero_above = 1'b1;
      if (state_q == DONE) begin
         for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (work_q[4*i +: 4] == 4'd0);
            blank_d[i] = zero_above;
         end
         blank_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
      else     blank_q <= blank_d;
   end

   assign bus.blank = blank_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomised self-checking bench for bin2bcd_seq against a decimal-arithmetic model.
module tb_bin2bcd_seq;
   localparam int BITSIZE = 16;
   localparam int DIGITS  = 5;
   localparam int LAT     = BITSIZE + 1;
   localparam int LIMIT   = 80;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   passed = 0;
   int   done_cnt = 0;

   always #5 clk = ~clk;

   bin2bcd_seq_if #(.BITSIZE(BITSIZE), .DIGITS(DIGITS)) bus ();

   bin2bcd_seq #(.BITSIZE(BITSIZE), .INDEXSIZE(4), .DIGITS(DIGITS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

   function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
      logic [4*DIGITS-1:0] r;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic [DIGITS-1:0] ref_blank(input int v);
      logic [DIGITS-1:0] r;
      int nd;
      nd = 1;
      while (v >= 10) begin
         v = v / 10;
         nd++;
      end
      for (int i = 0; i < DIGITS; i++) r[i] = (i >= nd);
      return r;
   endfunction

   // Leaves the bench at the falling edge just after the accepting edge (cycle 1).
   task automatic pulse_start(input logic [BITSIZE-1:0] v, input logic inv);
      @(negedge clk);
      bus.strt = 1'b1;
      bus.bin_in = v;
      bus.in_invalid = inv;
      @(negedge clk);
      bus.strt = 1'b0;
      bus.bin_in = BITSIZE'($urandom);
      bus.in_invalid = 1'($urandom);
   endtask

   task automatic wait_done(input int start, output int lat);
      lat = start;
      while (bus.done !== 1'b1 && lat < LIMIT) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      bus.strt = 1'b0;
      bus.bin_in = '0;
      bus.in_invalid = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (bus.bcd !== '0) $display("FAIL reset_bcd got %h want 0", bus.bcd); else passed++;
      total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else passed++;
      total++; if (bus.idle !== 1'b1) $display("FAIL reset_idle got %b want 1", bus.idle); else passed++;
`ifdef BIN2BCD_BLANK_EN
      total++; if (bus.blank !== 5'b11110) $display("FAIL reset_blank got %b want 11110", bus.blank); else passed++;
`endif
      rst = 1'b0;
   endtask

   task automatic test_directed();
      int vals[3] = '{0, 65535, 1234};
      int lat;
      foreach (vals[k]) begin
         pulse_start(BITSIZE'(vals[k]), 1'b0);
         total++; if (bus.idle !== 1'b0) $display("FAIL dir_busy v=%0d idle got %b want 0", vals[k], bus.idle); else passed++;
         wait_done(1, lat);
         total++; if (lat != LAT) $display("FAIL dir_latency v=%0d got %0d want %0d", vals[k], lat, LAT); else passed++;
         @(negedge clk);
         total++; if (bus.bcd !== ref_bcd(vals[k])) $display("FAIL dir_bcd v=%0d got %h want %h", vals[k], bus.bcd, ref_bcd(vals[k])); else passed++;
         total++; if (bus.idle !== 1'b1) $display("FAIL dir_idle v=%0d got %b want 1", vals[k], bus.idle); else passed++;
`ifdef BIN2BCD_BLANK_EN
         total++; if (bus.blank !== ref_blank(vals[k])) $display("FAIL dir_blank v=%0d got %b want %b", vals[k], bus.blank, ref_blank(vals[k])); else passed++;
`endif
      end
   endtask

   task automatic test_invalid();
      int lat;
      pulse_start(BITSIZE'(42), 1'b1);
      wait_done(1, lat);
      total++; if (lat != 1) $display("FAIL inv_latency got %0d want 1", lat); else passed++;
      @(negedge clk);
      total++; if (bus.bcd !== 20'hFFFFF) $display("FAIL inv_bcd got %h want fffff", bus.bcd); else passed++;
      total++; if (bus.idle !== 1'b1) $display("FAIL inv_idle got %b want 1", bus.idle); else passed++;
`ifdef BIN2BCD_BLANK_EN
      total++; if (bus.blank !== '0) $display("FAIL inv_blank got %b want 0", bus.blank); else passed++;
`endif
   endtask

   task automatic test_ignore_busy();
      int lat, snap;
      pulse_start(BITSIZE'(999), 1'b0);
      snap = done_cnt;
      repeat (3) @(negedge clk);
      total++; if (bus.idle !== 1'b0) $display("FAIL busy_idle got %b want 0", bus.idle); else passed++;
      bus.strt = 1'b1;
      bus.bin_in = BITSIZE'(5);
      bus.in_invalid = 1'b0;
      @(negedge clk);
      bus.strt = 1'b0;
      wait_done(5, lat);
      total++; if (lat != LAT) $display("FAIL busy_latency got %0d want %0d", lat, LAT); else passed++;
      repeat (4) @(negedge clk);
      total++; if (bus.bcd !== 20'h00999) $display("FAIL busy_bcd got %h want 00999", bus.bcd); else passed++;
      total++; if (done_cnt - snap != 1) $display("FAIL busy_done_pulses got %0d want 1", done_cnt - snap); else passed++;
   endtask

   task automatic test_abort();
      int lat, snap;
      pulse_start(BITSIZE'(500), 1'b0);
      wait_done(1, lat);
      @(negedge clk);
      total++; if (bus.bcd !== 20'h00500) $display("FAIL abort_first got %h want 00500", bus.bcd); else passed++;
      pulse_start(BITSIZE'(777), 1'b0);
      snap = done_cnt;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if (bus.bcd !== '0) $display("FAIL abort_bcd got %h want 0", bus.bcd); else passed++;
      total++; if (bus.idle !== 1'b1) $display("FAIL abort_idle got %b want 1", bus.idle); else passed++;
      repeat (25) @(negedge clk);
      total++; if (done_cnt != snap) $display("FAIL abort_no_done got %0d pulses want 0", done_cnt - snap); else passed++;
      pulse_start(BITSIZE'(321), 1'b0);
      wait_done(1, lat);
      @(negedge clk);
      total++; if (bus.bcd !== 20'h00321) $display("FAIL abort_after got %h want 00321", bus.bcd); else passed++;
   endtask

   task automatic test_back_to_back();
      int lat, gap;
      @(negedge clk);
      bus.strt = 1'b1;
      bus.bin_in = BITSIZE'(42);
      bus.in_invalid = 1'b0;
      @(negedge clk);
      wait_done(1, lat);
      total++; if (lat != LAT) $display("FAIL b2b_first_latency got %0d want %0d", lat, LAT); else passed++;
      @(negedge clk);
      total++; if (bus.bcd !== 20'h00042) $display("FAIL b2b_bcd got %h want 00042", bus.bcd); else passed++;
      wait_done(1, gap);
      total++; if (gap != LAT + 1) $display("FAIL b2b_gap got %0d want %0d", gap, LAT + 1); else passed++;
      bus.strt = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (bus.idle !== 1'b1) $display("FAIL b2b_idle got %b want 1", bus.idle); else passed++;
   endtask

   task automatic test_random();
      int v, lat;
      for (int n = 0; n < 16; n++) begin
         v = (n < 4) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 65535));
         pulse_start(BITSIZE'(v), 1'b0);
         wait_done(1, lat);
         total++; if (lat != LAT) $display("FAIL rnd_latency v=%0d got %0d want %0d", v, lat, LAT); else passed++;
         @(negedge clk);
         total++; if (bus.bcd !== ref_bcd(v)) $display("FAIL rnd_bcd v=%0d got %h want %h", v, bus.bcd, ref_bcd(v)); else passed++;
`ifdef BIN2BCD_BLANK_EN
         total++; if (bus.blank !== ref_blank(v)) $display("FAIL rnd_blank v=%0d got %b want %b", v, bus.blank, ref_blank(v)); else passed++;
`endif
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_invalid();
      test_ignore_busy();
      test_abort();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter that sits directly downstream of the parameterised divider. It takes the quotient or remainder and produces packed BCD digits for the display/readout stage. It uses the shift-add-3 (double dabble) method, one input bit per clock, with the same strt/idle handshake style as the divider. A divider not_valid flag is carried through as an error pattern.

Parameters:
BITSIZE, 16, width of binary input; must match divider BITSIZE
INDEXSIZE, 4, bit-counter width = log2(BITSIZE)
DIGITS, 5, BCD digits produced; must satisfy DIGITS >= ceil(BITSIZE*0.30103)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
strt  input  1  start request; sampled only in IDLE
bin_in  input  BITSIZE  unsigned binary value (divider quotient or remainder)
in_invalid  input  1  driven from divider not_valid; sampled with strt
bcd  output  4*DIGITS  packed BCD; digit 0 in [3:0]; registered
done  output  1  one-cycle pulse; bcd updated in this cycle
idle  output  1  high when in IDLE and ready for strt

Behaviour:
- Clocking and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: state=IDLE, bcd=0, done=0, idle=1, internal work registers=0.
- Reset asserted mid-conversion aborts the conversion. No done pulse is produced and bcd returns to 0.
- States: IDLE(00), CONV(01), DONE(10). Encoding 11 is unused and decodes to IDLE on the next edge.
- IDLE: idle=1.
  - strt=1 and in_invalid=0: bin_reg<=bin_in, work<=0, cnt<=BITSIZE-1, go to CONV.
  - strt=1 and in_invalid=1: work<=all 4'hF, go straight to DONE (no conversion).
  - strt=0: hold state.
- CONV, every edge:
  - Each work digit >=5 gets +3 (combinational adjust).
  - Then work<={adjusted[4*DIGITS-2:0], bin_reg[BITSIZE-1]} and bin_reg<=bin_reg<<1.
  - cnt decrements. When cnt==0 on this edge, go to DONE.
- DONE: done=1 (decoded from state), bcd<=work, next state IDLE.
- Latency: strt sampled at edge N; done is high during the cycle after edge N+BITSIZE; bcd is valid from edge N+BITSIZE+1. Default: 17 cycles from strt edge to bcd valid.
- Invalid-path latency: done is high during the cycle after edge N; bcd=all F after edge N+1.
- bcd holds its value until the next DONE or reset.
- strt while not idle is ignored. There is no queueing. strt held high continuously restarts conversion in the cycle after DONE.
- bin_in and in_invalid are sampled only at the accepting edge. Later changes have no effect.
- Width rules: the adjust step never carries across digits, because digit<=9 before the shift is guaranteed by the DIGITS constraint. Max input 2^BITSIZE-1 converts exactly.
- bin_in=0 yields all-zero digits after the full BITSIZE cycles. There is no early exit.

Optional Feature:
Macro BIN2BCD_BLANK_EN.
- Defined: adds output blank [DIGITS-1:0], registered alongside bcd. Bit i=1 when digit i and all higher digits are 0. Bit 0 is always 0.
- Defined, invalid path: blank=0.
- Reset value of blank: {DIGITS-1{1'b1}},1'b0.
- Not defined: port and logic absent; all else identical.

Decomposition:
- Package bin2bcd_pkg: state encodings IDLE/CONV/DONE, localparam ERR_DIGIT=4'hF, and a function computing the minimum DIGITS for a given BITSIZE (used in an elaboration check).
- Sub-module bcd_digit_adj: 4-bit in, 4-bit out, adds 3 when input >=5. Instantiated DIGITS times in a generate loop.

Test Plan:
- bin_in=0, strt pulse -> done at cycle 17; bcd=20'h00000; idle rises on the cycle after done.
- bin_in=16'hFFFF -> bcd=20'h65535 after 17 cycles. With BLANK_EN: blank=5'b00000.
- bin_in=1234 -> bcd=20'h01234. With BLANK_EN: blank=5'b10000.
- strt with in_invalid=1, bin_in=42 -> done on the next cycle; bcd=20'hFFFFF; no CONV state entered.
- strt with bin_in=999, then strt with bin_in=5 at cycle 5 -> second request ignored; bcd=20'h00999; exactly one done pulse.
- Convert 500, then assert rst at cycle 8 of a second conversion (bin_in=777) -> bcd=0, done never pulses, idle=1 the cycle after rst. A following strt with 321 gives 20'h00321.
